// File: rtl/cdc_xfer_pkg.sv
// cdc_xfer_pkg: shared state encoding for the CDC transfer arbiter
package cdc_xfer_pkg;
  localparam int ST_W = 1;
  typedef enum logic [ST_W-1:0] {IDLE, WAIT} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant starting the search at ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);
  logic found;
  logic [IDX_W-1:0] idx;
  // first requester at or after ptr, wrapping modulo N_REQ
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin sharing of one toggle-handshake CDC channel
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    fast_clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
  output logic                    xfer_req,
  output logic [DATA_W-1:0]       xfer_data,
  output logic [IDX_W-1:0]        xfer_src,
  input  logic                    xfer_ack,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        done_src,
  output logic                    timeout_err,
  output logic                    spur_err,
  input  logic                    err_clr
);
  localparam int TMR_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] T_MAX = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_prev, ack_edge, accept, timeout_hit;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] rr_ptr, win_idx, next_ptr;
  logic [N_REQ-1:0] grant;
  logic [DATA_W-1:0] win_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (.req(in_valid), .ptr(rr_ptr), .grant(grant));

  // no grant in the done cycle, leaving one idle cycle between transfers
  assign in_ready = (state == IDLE && !done) ? grant : '0;
  assign accept = |in_ready;
  assign ack_edge = sync[SYNC_STAGES-1] ^ sync_prev;
  assign timeout_hit = TIMEOUT != 0 && state == WAIT && !ack_edge && timer == T_LAST;
  assign next_ptr = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // encode the one-hot grant and select the winner's word
  always_comb begin
    win_idx = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) begin
        win_idx = IDX_W'(i);
        win_data = in_data[i*DATA_W +: DATA_W];
      end
  end

  // ack synchroniser with a trailing flop for toggle edge detection
  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], xfer_ack};
      sync_prev <= sync[SYNC_STAGES-1];
    end

  // transfer FSM: accept and toggle in IDLE, hold the word in WAIT until the ack edge
  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      xfer_req <= 1'b0;
      xfer_data <= '0;
      xfer_src <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      done_src <= '0;
      timer <= '0;
      rr_ptr <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          state <= WAIT;
          busy <= 1'b1;
          xfer_req <= ~xfer_req;
          xfer_data <= win_data;
          xfer_src <= win_idx;
          rr_ptr <= next_ptr;
          timer <= '0;
        end
      end else begin
        timer <= (timer == T_MAX) ? timer : timer + 1'b1;
        if (ack_edge) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          done_src <= xfer_src;
        end
      end
    end

  // sticky error flags; a set beats a simultaneous clear
  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) begin
      timeout_err <= 1'b0;
      spur_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit | (timeout_err & ~err_clr);
      spur_err <= (state == IDLE && ack_edge) | (spur_err & ~err_clr);
    end
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_cdc_xfer_arbiter;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int DATA_BITS = N * DW;

  logic fast_clk = 1'b0;
  logic rst_n = 1'b0;
  logic xfer_ack = 1'b0;
  logic err_clr = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [DATA_BITS-1:0] in_data = '0;
  logic [N-1:0] in_ready;
  logic xfer_req, busy, done, timeout_err, spur_err;
  logic [DW-1:0] xfer_data;
  logic [1:0] xfer_src, done_src;

  int checks = 0;
  int errors = 0;
  int rr_m = 0;
  logic req_m = 1'b0;
  logic terr_m = 1'b0;
  logic spur_m = 1'b0;

  always #5 fast_clk = ~fast_clk;

  cdc_xfer_arbiter #(.N_REQ(N), .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .fast_clk(fast_clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_src(xfer_src),
    .xfer_ack(xfer_ack), .busy(busy), .done(done), .done_src(done_src),
    .timeout_err(timeout_err), .spur_err(spur_err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge fast_clk);
    #1;
  endtask

  // round-robin rule: first valid requester at or after the model pointer
  function automatic int pick(input logic [N-1:0] v);
    logic [N-1:0] s;
    for (int k = 0; k < N; k++) begin
      s = v >> ((rr_m + k) % N);
      if (s[0]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic check_zero(input string p);
    chk({p, "_xfer_req"}, 32'(xfer_req), 0);
    chk({p, "_xfer_data"}, 32'(xfer_data), 0);
    chk({p, "_xfer_src"}, 32'(xfer_src), 0);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_done_src"}, 32'(done_src), 0);
    chk({p, "_timeout_err"}, 32'(timeout_err), 0);
    chk({p, "_spur_err"}, 32'(spur_err), 0);
    chk({p, "_in_ready"}, 32'(in_ready), 0);
  endtask

  task automatic model_reset;
    rr_m = 0;
    req_m = 1'b0;
    terr_m = 1'b0;
    spur_m = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    xfer_ack = 1'b0;
    in_valid = '0;
    err_clr = 1'b0;
    step;
    step;
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic clear_errs;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    terr_m = 1'b0;
    spur_m = 1'b0;
    chk("clr_timeout_err", 32'(timeout_err), 0);
    chk("clr_spur_err", 32'(spur_err), 0);
  endtask

  // one complete transfer; the ack toggles ack_at WAIT edges after the accept edge
  task automatic xfer(input logic [N-1:0] v, input logic [DATA_BITS-1:0] d, input int ack_at, input bit hold);
    int w, cons;
    logic [DW-1:0] word;
    in_valid = v;
    in_data = d;
    #1;
    w = pick(v);
    chk("in_ready_grant", 32'(in_ready), 32'(1) << w);
    word = DW'(d >> (w * DW));
    step;
    in_valid = hold ? v : '0;
    in_data = DATA_BITS'($urandom);
    req_m = ~req_m;
    rr_m = (w + 1) % N;
    chk("xfer_req_toggle", 32'(xfer_req), 32'(req_m));
    chk("xfer_data", 32'(xfer_data), 32'(word));
    chk("xfer_src", 32'(xfer_src), w);
    chk("busy_set", 32'(busy), 1);
    cons = ack_at + SS + 1;
    for (int t = 1; t <= cons; t++) begin
      if (t - 1 == ack_at) xfer_ack = ~xfer_ack;
      step;
      if (t < cons && t == TO) terr_m = 1'b1;
      chk("done", 32'(done), 32'(t == cons));
      chk("busy", 32'(busy), 32'(t < cons));
      chk("timeout_err", 32'(timeout_err), 32'(terr_m));
      chk("xfer_data_hold", 32'(xfer_data), 32'(word));
      chk("in_ready_blocked", 32'(in_ready), 0);
    end
    chk("done_src", 32'(done_src), w);
    in_valid = '1;
    #1;
    chk("in_ready_done_cycle", 32'(in_ready), 0);
    in_valid = '0;
    step;
    chk("done_clear", 32'(done), 0);
    chk("spur_err_hold", 32'(spur_err), 32'(spur_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    do_reset();
    // single requester, fixed word
    xfer(4'b0001, 16'h000A, 0, 1'b0);
    // fairness with every requester asserting continuously
    do_reset();
    for (int i = 0; i < 5; i++) xfer(4'b1111, DATA_BITS'($urandom), $urandom_range(0, 3), 1'b1);
    // random valid patterns and ack delays, some long enough to time out
    for (int i = 0; i < 12; i++)
      xfer(N'($urandom_range(1, 15)), DATA_BITS'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    clear_errs();
    // ack held well past the timeout, then arriving late
    xfer(4'b0100, DATA_BITS'($urandom), 12, 1'b0);
    chk("timeout_sticky", 32'(timeout_err), 1);
    clear_errs();
    // ack edge lands exactly on the timeout cycle
    xfer(4'b1000, DATA_BITS'($urandom), TO - SS - 1, 1'b0);
    chk("timeout_tie", 32'(timeout_err), 0);
    // spurious ack while idle
    xfer_ack = ~xfer_ack;
    for (int t = 1; t <= SS + 1; t++) begin
      step;
      if (t == SS + 1) spur_m = 1'b1;
      chk("spur_err", 32'(spur_err), 32'(spur_m));
      chk("spur_no_done", 32'(done), 0);
      chk("spur_idle", 32'(busy), 0);
    end
    xfer(4'b0010, DATA_BITS'($urandom), 1, 1'b0);
    clear_errs();
    // reset in the middle of a transfer
    in_valid = 4'b0100;
    in_data = DATA_BITS'($urandom);
    #1;
    w = pick(in_valid);
    chk("mid_grant", 32'(in_ready), 32'(1) << w);
    step;
    in_valid = '0;
    chk("mid_busy", 32'(busy), 1);
    step;
    step;
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    xfer_ack = 1'b0;
    step;
    rst_n = 1'b1;
    model_reset();
    xfer(4'b0010, DATA_BITS'($urandom), 1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
